// File: rtl/ascon_pack.sv
// Shared Ascon types and constants: state layout, column count, FSM encoding
// and column get/put helpers used by the inverse-substitution layer.
package ascon_pack;

  localparam int NB_COLS  = 64;
  localparam int NB_WORDS = 5;

  // Ascon state: index 0 is x0, index 4 is x4; each word is 64 bits.
  typedef logic [NB_WORDS-1:0][NB_COLS-1:0] type_state;

  // FSM encoding (plain constants so legacy tools can consume them).
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Gather column j as {x0[j],x1[j],x2[j],x3[j],x4[j]} (x0 is the MSB).
  function automatic logic [4:0] get_column(input type_state s, input logic [5:0] j);
    get_column = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
  endfunction

  // Scatter a 5-bit column back into the same bit position j.
  function automatic type_state put_column(input type_state s, input logic [5:0] j,
                                           input logic [4:0] c);
    type_state r;
    r       = s;
    r[0][j] = c[4];
    r[1][j] = c[3];
    r[2][j] = c[2];
    r[3][j] = c[1];
    r[4][j] = c[0];
    put_column = r;
  endfunction

endpackage

// File: rtl/pinv_subst_sbox_inv.sv
// Inverse Ascon 5-bit S-box, purely combinational lookup.
module sbox_inv (
  input  logic [4:0] in_i,
  output logic [4:0] out_o
);

  // Table lookup from substituted value back to the original column.
  always_comb begin
    out_o = 5'h00;
    case (in_i)
      5'h00: out_o = 5'h14;
      5'h01: out_o = 5'h1A;
      5'h02: out_o = 5'h07;
      5'h03: out_o = 5'h0D;
      5'h04: out_o = 5'h00;
      5'h05: out_o = 5'h09;
      5'h06: out_o = 5'h0E;
      5'h07: out_o = 5'h12;
      5'h08: out_o = 5'h0A;
      5'h09: out_o = 5'h06;
      5'h0A: out_o = 5'h1D;
      5'h0B: out_o = 5'h01;
      5'h0C: out_o = 5'h19;
      5'h0D: out_o = 5'h15;
      5'h0E: out_o = 5'h13;
      5'h0F: out_o = 5'h1E;
      5'h10: out_o = 5'h18;
      5'h11: out_o = 5'h16;
      5'h12: out_o = 5'h0B;
      5'h13: out_o = 5'h11;
      5'h14: out_o = 5'h03;
      5'h15: out_o = 5'h05;
      5'h16: out_o = 5'h1C;
      5'h17: out_o = 5'h1F;
      5'h18: out_o = 5'h17;
      5'h19: out_o = 5'h1B;
      5'h1A: out_o = 5'h04;
      5'h1B: out_o = 5'h08;
      5'h1C: out_o = 5'h0F;
      5'h1D: out_o = 5'h0C;
      5'h1E: out_o = 5'h10;
      5'h1F: out_o = 5'h02;
      default: out_o = 5'h00;
    endcase
  end

endmodule

// File: rtl/pinv_subst.sv
// Iterative inverse Ascon substitution layer: COLS_PER_CYCLE columns of the
// captured state are replaced in place each RUN cycle, then a one-cycle DONE.
module pinv_subst
  import ascon_pack::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic      clock_i,
  input  logic      resetb_i,
  input  logic      start_i,
  input  type_state state_i,
  output type_state state_o,
  output logic      busy_o,
  output logic      done_o
);

  // Counter step; with 64 columns per cycle the 6-bit counter wraps straight to 0.
  localparam logic [6:0] STEP = 7'(COLS_PER_CYCLE);

  logic [1:0] fsm_q, fsm_d;
  logic [5:0] cnt_q, cnt_d;
  type_state  work_q, work_d;
  logic [6:0] cnt_sum_s;

  logic [5:0] col_idx_s [COLS_PER_CYCLE];
  logic [4:0] sbox_in_s [COLS_PER_CYCLE];
  logic [4:0] sbox_out_s[COLS_PER_CYCLE];

  // One inverse S-box per column handled in a cycle; cnt is always a multiple
  // of COLS_PER_CYCLE so cnt+k stays within 0..63.
  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    localparam logic [5:0] OFF = 6'(k);

    assign col_idx_s[k] = cnt_q + OFF;
    assign sbox_in_s[k] = get_column(work_q, col_idx_s[k]);

    sbox_inv u_sbox_inv (
      .in_i  (sbox_in_s[k]),
      .out_o (sbox_out_s[k])
    );
  end

  assign cnt_sum_s = {1'b0, cnt_q} + STEP;

  // Next-state logic: capture on start in IDLE, substitute in RUN, pulse in DONE.
  always_comb begin
    fsm_d  = fsm_q;
    cnt_d  = cnt_q;
    work_d = work_q;
    case (fsm_q)
      ST_IDLE: begin
        if (start_i) begin
          work_d = state_i;
          cnt_d  = 6'd0;
          fsm_d  = ST_RUN;
        end else begin
          fsm_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          work_d = put_column(work_d, col_idx_s[k], sbox_out_s[k]);
        end
        cnt_d = cnt_sum_s[5:0];
        if (cnt_sum_s == 7'(NB_COLS)) begin
          fsm_d = ST_DONE;
        end else begin
          fsm_d = ST_RUN;
        end
      end
      ST_DONE: begin
        fsm_d = ST_IDLE;
      end
      default: begin
        fsm_d = ST_IDLE;
        cnt_d = 6'd0;
      end
    endcase
  end

  // State registers; reset aborts any operation and clears the result.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q  <= ST_IDLE;
      cnt_q  <= 6'd0;
      work_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      work_q <= work_d;
    end
  end

  assign state_o = work_q;
  assign busy_o  = (fsm_q == ST_RUN);
  assign done_o  = (fsm_q == ST_DONE);

endmodule
